// File: rtl/percept_array.sv
// Address-matched serial perceptron node: bit-serial weight/bias load, sequential MAC inference,
// serial result return. Define PERCEPT_RELU_EN to clamp negative results to zero before storing.
module percept_array #(
    parameter int         N_IN  = 4,
    parameter int         W     = 8,
    parameter int         ACC_W = 19,
    parameter logic [7:0] ADDR  = 8'hAA
) (
    input  logic clk,
    input  logic nRst,
    input  logic in,
    output logic out,
    output logic out_valid,
    output logic fire,
    output logic busy
);
    localparam int PAY_W = N_IN * W;
    localparam int CNT_W = ($clog2(PAY_W + 1) > 4) ? $clog2(PAY_W + 1) : 4;
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int TXC_W = $clog2(ACC_W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_CMD, S_PAYLOAD, S_SKIP, S_MAC, S_TX
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [6:0]              addr_q;
    logic                    match_q;
    logic [1:0]              cmd_q;
    logic [PAY_W-1:0]        stage_q;
    logic [N_IN-1:0][W-1:0]  w_q;
    logic signed [ACC_W-1:0] bias_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] result_q;
    logic [ACC_W-1:0]        tx_sh_q;
    logic [IDX_W-1:0]        idx_q;
    logic [TXC_W-1:0]        txc_q;
    logic                    out_q;
    logic                    out_valid_q;
    logic                    fire_q;

    logic [PAY_W-1:0]        stage_nxt;
    logic [N_IN-1:0][W-1:0]  nxt_word;
    logic [N_IN-1:0][W-1:0]  smp;
    logic [CNT_W-1:0]        pay_last;
    logic [1:0]              cmd_full;
    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] res_nxt;

    assign stage_nxt = {stage_q[PAY_W-2:0], in};
    assign cmd_full  = {cmd_q[0], in};
    assign pay_last  = (cmd_q == 2'b01) ? CNT_W'(W - 1) : CNT_W'(PAY_W - 1);

    // Word 0 arrives first, so after the full payload it sits in the top W bits.
    always_comb begin
        nxt_word = '0;
        smp      = '0;
        for (int i = 0; i < N_IN; i++) begin
            nxt_word[i] = stage_nxt[(N_IN-i)*W-1 -: W];
            smp[i]      = stage_q[(N_IN-i)*W-1 -: W];
        end
    end

    assign prod    = $signed(w_q[idx_q]) * $signed(smp[idx_q]);
    assign acc_sum = acc_q + {{(ACC_W-2*W){prod[2*W-1]}}, prod};

`ifdef PERCEPT_RELU_EN
    assign res_nxt = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
    assign res_nxt = acc_sum;
`endif

    always_ff @(posedge clk) begin
        if (nRst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            match_q     <= 1'b0;
            cmd_q       <= '0;
            stage_q     <= '0;
            w_q         <= '0;
            bias_q      <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            tx_sh_q     <= '0;
            idx_q       <= '0;
            txc_q       <= '0;
            out_q       <= 1'b1;
            out_valid_q <= 1'b0;
            fire_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!in) state_q <= S_ADDR;
                end
                S_ADDR: begin
                    addr_q <= {addr_q[5:0], in};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(7)) begin
                        match_q <= ({addr_q, in} == ADDR);
                        cnt_q   <= '0;
                        state_q <= S_CMD;
                    end
                end
                S_CMD: begin
                    cmd_q <= cmd_full;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= '0;
                        txc_q   <= '0;
                        tx_sh_q <= result_q;
                        // A mismatched READ has no payload to skip.
                        if (match_q && cmd_full == 2'b11)      state_q <= S_TX;
                        else if (match_q)                     state_q <= S_PAYLOAD;
                        else if (cmd_full == 2'b11)           state_q <= S_IDLE;
                        else                                  state_q <= S_SKIP;
                    end
                end
                S_PAYLOAD: begin
                    stage_q <= stage_nxt;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == pay_last) begin
                        cnt_q <= '0;
                        case (cmd_q)
                            2'b00: begin
                                w_q     <= nxt_word;
                                state_q <= S_IDLE;
                            end
                            2'b01: begin
                                bias_q  <= {{(ACC_W-W){stage_nxt[W-1]}}, stage_nxt[W-1:0]};
                                state_q <= S_IDLE;
                            end
                            2'b10: begin
                                acc_q   <= bias_q;
                                idx_q   <= '0;
                                state_q <= S_MAC;
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_SKIP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == pay_last) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_sum;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(N_IN - 1)) begin
                        result_q <= res_nxt;
                        tx_sh_q  <= res_nxt;
                        fire_q   <= ~acc_sum[ACC_W-1];
                        txc_q    <= '0;
                        state_q  <= S_TX;
                    end
                end
                S_TX: begin
                    if (txc_q == TXC_W'(ACC_W)) begin
                        out_q       <= 1'b1;
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        out_q       <= tx_sh_q[ACC_W-1];
                        out_valid_q <= 1'b1;
                        tx_sh_q     <= {tx_sh_q[ACC_W-2:0], 1'b0};
                        txc_q       <= txc_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign fire      = fire_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_percept_array.sv
// Self-checking bench for percept_array: directed vector table, corner sequences and
// randomized inferences compared against an arithmetic reference model.
module tb_percept_array;
    localparam int         N_IN  = 4;
    localparam int         W     = 8;
    localparam int         ACC_W = 19;
    localparam logic [7:0] ADDR  = 8'hAA;

`ifdef PERCEPT_RELU_EN
    localparam logic [ACC_W-1:0] RES_NEG = '0;
    localparam logic [ACC_W-1:0] RES_M1  = '0;
`else
    localparam logic [ACC_W-1:0] RES_NEG = 19'h70200;
    localparam logic [ACC_W-1:0] RES_M1  = 19'h7FFFF;
`endif

    typedef logic [N_IN-1:0][W-1:0] wvec_t;
    typedef struct packed {
        wvec_t            w;
        logic [W-1:0]     b;
        wvec_t            s;
        logic [ACC_W-1:0] res;
        logic             fire;
    } vec_t;

    logic clk = 1'b0;
    logic nRst, in, out, out_valid, fire, busy;
    int   n_chk = 0;
    int   n_fail = 0;

    wvec_t m_w;
    int    m_b;
    int    m_res;
    logic  m_fire;

    percept_array #(.N_IN(N_IN), .W(W), .ACC_W(ACC_W), .ADDR(ADDR)) dut (
        .clk(clk), .nRst(nRst), .in(in), .out(out),
        .out_valid(out_valid), .fire(fire), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic wvec_t mk(input int a0, input int a1, input int a2, input int a3);
        wvec_t v;
        v[0] = a0[W-1:0];
        v[1] = a1[W-1:0];
        v[2] = a2[W-1:0];
        v[3] = a3[W-1:0];
        return v;
    endfunction

    task automatic tick(input logic b);
        in = b;
        @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] a, input logic [1:0] c, input wvec_t pay, input int nwords);
        tick(1'b0);
        for (int i = 7; i >= 0; i--) tick(a[i]);
        for (int i = 1; i >= 0; i--) tick(c[i]);
        for (int k = 0; k < nwords; k++)
            for (int j = W - 1; j >= 0; j--) tick(pay[k][j]);
        in = 1'b1;
    endtask

    task automatic load_w(input logic [7:0] a, input wvec_t w);
        frame(a, 2'b00, w, N_IN);
        if (a == ADDR) m_w = w;
    endtask

    task automatic load_b(input logic [7:0] a, input logic [W-1:0] b);
        wvec_t p;
        p = '0;
        p[0] = b;
        frame(a, 2'b01, p, 1);
        if (a == ADDR) m_b = int'($signed(b));
    endtask

    // Waits for the result with a bounded budget, toggling `in` while the node should ignore it.
    task automatic get_result(input string tag, input int exp_lat, output logic [ACC_W-1:0] val);
        int lat, nb;
        lat = 0;
        nb  = 0;
        val = '0;
        while (out_valid !== 1'b1 && lat < 40) begin
            in = (lat < exp_lat) ? 1'($urandom_range(1)) : 1'b1;
            @(negedge clk);
            lat++;
        end
        in = 1'b1;
        check({tag, " latency"}, lat, exp_lat);
        while (out_valid === 1'b1 && nb < ACC_W + 4) begin
            val = {val[ACC_W-2:0], out};
            nb++;
            @(negedge clk);
        end
        check({tag, " valid count"}, nb, ACC_W);
        check({tag, " idle out"}, {out, out_valid, busy}, 3'b100);
    endtask

    task automatic infer(input string tag, input wvec_t s, output logic [ACC_W-1:0] got);
        int sum;
        frame(ADDR, 2'b10, s, N_IN);
        sum = m_b;
        for (int i = 0; i < N_IN; i++)
            sum += int'($signed(m_w[i])) * int'($signed(s[i]));
        m_fire = (sum >= 0);
`ifdef PERCEPT_RELU_EN
        m_res = (sum < 0) ? 0 : sum;
`else
        m_res = sum;
`endif
        get_result(tag, N_IN + 1, got);
    endtask

    task automatic read(input string tag, output logic [ACC_W-1:0] got);
        frame(ADDR, 2'b11, '0, 0);
        get_result(tag, 1, got);
    endtask

    // Mismatched frame: busy must stay high through the last payload bit and drop right after it.
    task automatic skip_frame(input string tag, input logic [1:0] c, input int nbits);
        tick(1'b0);
        for (int i = 7; i >= 0; i--) tick(~ADDR[i]);
        for (int i = 1; i >= 0; i--) tick(c[i]);
        for (int k = 0; k < nbits - 1; k++) tick(k % 8 >= 5);
        check({tag, " busy before last"}, {busy, out_valid, out}, 3'b101);
        tick(1'b1);
        check({tag, " busy after last"}, {busy, out_valid, out}, 3'b001);
    endtask

    initial begin
        vec_t             tbl [5];
        logic [ACC_W-1:0] got, prev;
        wvec_t            rw, rs;
        logic [W-1:0]     rb;
        int               lat;

        tbl[0] = '{w: mk(1, 2, 3, 4),           b: 8'd0,   s: mk(1, 1, 1, 1),
                   res: 19'd10,  fire: 1'b1};
        tbl[1] = '{w: mk(-128, -128, -128, -128), b: 8'd0, s: mk(127, 127, 127, 127),
                   res: RES_NEG, fire: 1'b0};
        tbl[2] = '{w: mk(1, 0, 0, 0),           b: 8'hFB,  s: mk(5, 9, 9, 9),
                   res: 19'd0,   fire: 1'b1};
        tbl[3] = '{w: mk(1, 0, 0, 0),           b: 8'hFB,  s: mk(4, 9, 9, 9),
                   res: RES_M1,  fire: 1'b0};
        tbl[4] = '{w: mk(-128, -128, -128, -128), b: 8'd127, s: mk(-128, -128, -128, -128),
                   res: 19'h1007F, fire: 1'b1};

        m_w = '0; m_b = 0; m_res = 0; m_fire = 1'b0;
        in = 1'b1;
        nRst = 1'b1;
        repeat (3) @(negedge clk);
        nRst = 1'b0;
        check("reset outputs", {out, out_valid, fire, busy}, 4'b1000);

        read("read before infer", got);
        check("read before infer value", got, '0);

        for (int t = 0; t < 5; t++) begin
            load_w(ADDR, tbl[t].w);
            load_b(ADDR, tbl[t].b);
            check($sformatf("vec%0d fire held over loads", t), fire, (t == 0) ? 1'b0 : tbl[t-1].fire);
            infer($sformatf("vec%0d", t), tbl[t].s, got);
            check($sformatf("vec%0d result", t), got, tbl[t].res);
            check($sformatf("vec%0d fire", t), fire, tbl[t].fire);
        end

        read("reread", prev);
        check("reread value", prev, tbl[4].res);

        // Frames for another node carry no effect on weights or bias.
        load_w(ADDR, mk(2, -3, 5, 1));
        load_b(ADDR, 8'd3);
        skip_frame("skip load_w", 2'b00, N_IN * W);
        skip_frame("skip load_b", 2'b01, W);
        skip_frame("skip infer", 2'b10, N_IN * W);
        infer("after skip", mk(10, 20, -30, 4), got);
        check("after skip result", got, m_res[ACC_W-1:0]);
        check("after skip fire", fire, m_fire);
        prev = got;

        load_w(ADDR, mk(7, 7, 7, 7));
        check("fire after load_w", fire, m_fire);
        read("read after load_w", got);
        check("read after load_w value", got, prev);

        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < N_IN; i++) begin
                rw[i] = 8'($urandom);
                rs[i] = 8'($urandom);
            end
            rb = 8'($urandom);
            if (r % 3 == 0) load_w(ADDR, rw);
            if (r % 2 == 0) load_b(ADDR, rb);
            if (r % 4 == 1) skip_frame($sformatf("rand%0d skip", r), 2'b00, N_IN * W);
            infer($sformatf("rand%0d", r), rs, got);
            check($sformatf("rand%0d result", r), got, m_res[ACC_W-1:0]);
            check($sformatf("rand%0d fire", r), fire, m_fire);
        end

        // Reset during the 5th transmitted bit of a positive result.
        load_w(ADDR, mk(1, 1, 1, 1));
        load_b(ADDR, 8'd0);
        frame(ADDR, 2'b10, mk(3, 3, 3, 3), N_IN);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("midtx latency", lat, N_IN + 1);
        repeat (4) @(negedge clk);
        check("midtx still sending", {out_valid, busy, fire}, 3'b111);
        nRst = 1'b1;
        @(negedge clk);
        nRst = 1'b0;
        check("midtx reset outputs", {out, out_valid, busy, fire}, 4'b1000);
        m_w = '0; m_b = 0; m_res = 0; m_fire = 1'b0;
        read("read after reset", got);
        check("read after reset value", got, '0);
        check("fire after reset read", fire, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
